sprite_renderer: RTL and testbench

Pixel-pipeline stage directly downstream of the 640x480 timing generator. It consumes the registered `x`/`y`/`active`/`hsync`/`vsync`/`frame_tick` stream and produces final 6-bit RGB: sky background plus two 16x16 plane sprites, with priority and per-frame collision detection. Sync signals are delayed to match pixel latency, so the outputs drive the VGA pins directly.

---
 rtl/sprite_renderer.sv | 170 +++++++++++++++++
 tb/tb_sprite_renderer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// sprite_renderer: VGA pixel stage drawing a sky background and two 16x16
// plane sprites. Sprite 0 has priority over sprite 1, and overlaps are
// reported once per frame. RGB and syncs arrive two cycles after the pixel
// stream that produced them.
module sprite_renderer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       frame_tick,
    input  logic [9:0] p0_x,
    input  logic [8:0] p0_y,
    input  logic       p0_dir,
    input  logic       p0_en,
    input  logic [9:0] p1_x,
    input  logic [8:0] p1_y,
    input  logic       p1_dir,
    input  logic       p1_en,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       collide
);

    // Plane silhouette in mirrored sprite coordinates: fuselage, wings, tail
    function automatic logic shape_opaque(input logic [3:0] um, input logic [3:0] v);
        return (v == 4'd7) || (v == 4'd8) ||
               ((um >= 4'd5) && (um <= 4'd7)) ||
               ((um <= 4'd1) && (v >= 4'd4) && (v <= 4'd11));
    endfunction

    // Shadow copies of the sprite attributes
    logic [9:0] s0_x_r, s1_x_r;
    logic [8:0] s0_y_r, s1_y_r;
    logic       s0_dir_r, s1_dir_r, s0_en_r, s1_en_r;

    // Stage-1 combinational terms
    logic [10:0] u0_s, v0_s, u1_s, v1_s;
    logic        in0_s, in1_s;
    logic [3:0]  um0_s, um1_s;

    // Stage-1 registers
    logic       in0_r, in1_r;
    logic [3:0] um0_r, um1_r, v0_r, v1_r;
    logic       act_r, hs1_r, vs1_r;

    // Stage-2 combinational terms and registers
    logic       op0_s, op1_s, hit_s;
    logic [5:0] rgb_s;
    logic [5:0] rgb_r;
    logic       hs2_r, vs2_r;
    logic       hit_acc_r, collide_r;

    // Latch sprite attributes at frame start so mid-frame edits wait a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_x_r   <= 10'd0;
            s0_y_r   <= 9'd0;
            s0_dir_r <= 1'b0;
            s0_en_r  <= 1'b0;
            s1_x_r   <= 10'd0;
            s1_y_r   <= 9'd0;
            s1_dir_r <= 1'b0;
            s1_en_r  <= 1'b0;
        end else if (frame_tick) begin
            s0_x_r   <= p0_x;
            s0_y_r   <= p0_y;
            s0_dir_r <= p0_dir;
            s0_en_r  <= p0_en;
            s1_x_r   <= p1_x;
            s1_y_r   <= p1_y;
            s1_dir_r <= p1_dir;
            s1_en_r  <= p1_en;
        end
    end

    // Box test and mirrored sprite coordinates; no wrap past screen edges
    always_comb begin
        u0_s  = {1'b0, x} - {1'b0, s0_x_r};
        v0_s  = {2'b00, y} - {2'b00, s0_y_r};
        u1_s  = {1'b0, x} - {1'b0, s1_x_r};
        v1_s  = {2'b00, y} - {2'b00, s1_y_r};
        in0_s = s0_en_r && (x >= s0_x_r) && (u0_s < 11'd16) &&
                (y >= s0_y_r) && (v0_s < 11'd16);
        in1_s = s1_en_r && (x >= s1_x_r) && (u1_s < 11'd16) &&
                (y >= s1_y_r) && (v1_s < 11'd16);
        um0_s = s0_dir_r ? (4'd15 - u0_s[3:0]) : u0_s[3:0];
        um1_s = s1_dir_r ? (4'd15 - u1_s[3:0]) : u1_s[3:0];
    end

    // Stage 1: capture box hits, sprite coordinates and delayed controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in0_r <= 1'b0;
            in1_r <= 1'b0;
            um0_r <= 4'd0;
            um1_r <= 4'd0;
            v0_r  <= 4'd0;
            v1_r  <= 4'd0;
            act_r <= 1'b0;
            hs1_r <= 1'b1;
            vs1_r <= 1'b1;
        end else begin
            in0_r <= in0_s;
            in1_r <= in1_s;
            um0_r <= um0_s;
            um1_r <= um1_s;
            v0_r  <= v0_s[3:0];
            v1_r  <= v1_s[3:0];
            act_r <= active_in;
            hs1_r <= hsync_in;
            vs1_r <= vsync_in;
        end
    end

    // Opacity, overlap and colour selection with sprite 0 on top
    always_comb begin
        op0_s = in0_r && shape_opaque(um0_r, v0_r);
        op1_s = in1_r && shape_opaque(um1_r, v1_r);
        hit_s = act_r && op0_s && op1_s;
        if (!act_r) begin
            rgb_s = 6'b00_00_00;
        end else if (op0_s) begin
            rgb_s = 6'b11_00_00;
        end else if (op1_s) begin
            rgb_s = 6'b00_00_11;
        end else begin
            rgb_s = 6'b00_01_10;
        end
    end

    // Stage 2: register pixel colour and output syncs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= 6'd0;
            hs2_r <= 1'b1;
            vs2_r <= 1'b1;
        end else begin
            rgb_r <= rgb_s;
            hs2_r <= hs1_r;
            vs2_r <= vs1_r;
        end
    end

    // Accumulate overlaps over a frame; publish and clear at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_acc_r <= 1'b0;
            collide_r <= 1'b0;
        end else if (frame_tick) begin
            collide_r <= hit_acc_r | hit_s;
            hit_acc_r <= 1'b0;
        end else begin
            hit_acc_r <= hit_acc_r | hit_s;
        end
    end

    assign r       = rgb_r[5:4];
    assign g       = rgb_r[3:2];
    assign b       = rgb_r[1:0];
    assign hsync_o = hs2_r;
    assign vsync_o = vs2_r;
    assign collide = collide_r;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: fixed pixel vectors, hand-written multi-cycle
// sequences and randomized traffic against a behavioural pixel model.
module tb_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, active_in = 1'b0;
    logic [9:0] x = 10'd0;
    logic [8:0] y = 9'd0;
    logic       frame_tick = 1'b0;
    logic [9:0] p0_x = 10'd0, p1_x = 10'd0;
    logic [8:0] p0_y = 9'd0, p1_y = 9'd0;
    logic       p0_dir = 1'b0, p0_en = 1'b0, p1_dir = 1'b0, p1_en = 1'b0;
    logic [1:0] r, g, b;
    logic       hsync_o, vsync_o, collide;

    sprite_renderer dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .active_in(active_in), .x(x), .y(y), .frame_tick(frame_tick),
        .p0_x(p0_x), .p0_y(p0_y), .p0_dir(p0_dir), .p0_en(p0_en),
        .p1_x(p1_x), .p1_y(p1_y), .p1_dir(p1_dir), .p1_en(p1_en),
        .r(r), .g(g), .b(b), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .collide(collide)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] RED  = 6'b11_00_00;
    localparam logic [5:0] BLUE = 6'b00_00_11;
    localparam logic [5:0] SKY  = 6'b00_01_10;

    int total = 0;
    int bad   = 0;

    // Model state: shadowed sprites, pending pixel result, collision tracking
    int         sh_x[2], sh_y[2], sh_d[2], sh_e[2];
    logic [7:0] exp_prev;      // {rgb, hsync, vsync} of the pixel one cycle back
    logic       hit_prev, acc, col_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plane shape from the sprite rules, in plain integer arithmetic
    function automatic bit opaque(int n, int px, int py);
        int u, v, um;
        u = px - sh_x[n];
        v = py - sh_y[n];
        if (sh_e[n] == 0 || u < 0 || u > 15 || v < 0 || v > 15) return 1'b0;
        um = (sh_d[n] != 0) ? 15 - u : u;
        return (v == 7 || v == 8) || (um >= 5 && um <= 7) ||
               (um <= 1 && v >= 4 && v <= 11);
    endfunction

    function automatic logic [5:0] colour(int px, int py, bit act);
        if (!act) return 6'd0;
        if (opaque(0, px, py)) return RED;
        if (opaque(1, px, py)) return BLUE;
        return SKY;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            sh_x[n] = 0; sh_y[n] = 0; sh_d[n] = 0; sh_e[n] = 0;
        end
        exp_prev = {6'd0, 2'b11};
        hit_prev = 1'b0;
        acc      = 1'b0;
        col_exp  = 1'b0;
    endtask

    // One pixel clock: apply inputs, clock, check outputs against the model
    task automatic drive(input int xi, input int yi, input bit a, input bit hs,
                         input bit vs, input bit ft);
        x = 10'(xi); y = 9'(yi); active_in = a;
        hsync_in = hs; vsync_in = vs; frame_tick = ft;
        @(posedge clk);
        #1;
        chk("rgb", {26'd0, r, g, b}, {26'd0, exp_prev[7:2]});
        chk("hsync_o", {31'd0, hsync_o}, {31'd0, exp_prev[1]});
        chk("vsync_o", {31'd0, vsync_o}, {31'd0, exp_prev[0]});
        if (ft) begin
            col_exp = acc | hit_prev;
            acc = 1'b0;
        end else begin
            acc = acc | hit_prev;
        end
        chk("collide", {31'd0, collide}, {31'd0, col_exp});
        exp_prev = {colour(xi, yi, a), hs, vs};
        hit_prev = a && opaque(0, xi, yi) && opaque(1, xi, yi);
        if (ft) begin
            sh_x[0] = p0_x; sh_y[0] = p0_y; sh_d[0] = p0_dir; sh_e[0] = p0_en;
            sh_x[1] = p1_x; sh_y[1] = p1_y; sh_d[1] = p1_dir; sh_e[1] = p1_en;
        end
    endtask

    // Hold reset for n cycles with toggling inputs; outputs must stay at reset values
    task automatic do_reset(input int n);
        #1;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            x = 10'($urandom_range(0, 639)); y = 9'($urandom_range(0, 479));
            active_in = 1'($urandom); hsync_in = 1'($urandom);
            vsync_in = 1'($urandom); frame_tick = 1'($urandom);
            p0_en = 1'($urandom); p1_en = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset_rgb", {26'd0, r, g, b}, 32'd0);
            chk("reset_sync", {30'd0, hsync_o, vsync_o}, 32'd3);
            chk("reset_collide", {31'd0, collide}, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    // Present one pixel and return the colour that comes out for it
    task automatic probe(input int px, input int py, output logic [5:0] rgb);
        drive(px, py, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        rgb = {r, g, b};
    endtask

    task automatic tick();
        drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    typedef struct {
        int p0x, p0y, p0d, p0e, p1x, p1y, p1e;
        int px, py;
        logic [5:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[14];
        logic [5:0] got;

        vecs[0]  = '{100, 50, 0, 1,   0,   0, 0, 106,  50, RED};
        vecs[1]  = '{100, 50, 0, 1,   0,   0, 0, 102,  50, SKY};
        vecs[2]  = '{100, 50, 0, 1,   0,   0, 0, 100,  60, RED};
        vecs[3]  = '{100, 50, 0, 1,   0,   0, 0, 115,  57, RED};
        vecs[4]  = '{100, 50, 1, 1,   0,   0, 0, 109,  50, RED};
        vecs[5]  = '{100, 50, 1, 1,   0,   0, 0, 114,  60, RED};
        vecs[6]  = '{100, 50, 1, 1,   0,   0, 0, 100,  60, SKY};
        vecs[7]  = '{200, 100, 0, 1, 200, 100, 1, 200, 107, RED};
        vecs[8]  = '{200, 100, 0, 0, 200, 100, 1, 200, 107, BLUE};
        vecs[9]  = '{632, 470, 0, 1,   0,   0, 0, 637, 470, RED};
        vecs[10] = '{632, 470, 0, 1,   0,   0, 0, 639, 477, RED};
        vecs[11] = '{632, 470, 0, 1,   0,   0, 0,   0, 470, SKY};
        vecs[12] = '{632, 470, 0, 1,   0,   0, 0, 632, 470, SKY};
        vecs[13] = '{632, 470, 0, 1,   0,   0, 0, 637,   0, SKY};

        do_reset(5);

        // Mini frame with both sprites disabled: sky, blanking and sync delay
        p0_en = 1'b0; p1_en = 1'b0;
        tick();
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 24; col++) begin
                drive(col, row, (col < 16) && (row < 6), !(col >= 18 && col < 21),
                      !(row == 7), 1'b0);
            end
        end

        // Table of single pixels, each after a frame_tick latching the sprites
        for (int i = 0; i < 14; i++) begin
            p0_x = 10'(vecs[i].p0x); p0_y = 9'(vecs[i].p0y);
            p0_dir = 1'(vecs[i].p0d); p0_en = 1'(vecs[i].p0e);
            p1_x = 10'(vecs[i].p1x); p1_y = 9'(vecs[i].p1y);
            p1_dir = 1'b0; p1_en = 1'(vecs[i].p1e);
            tick();
            probe(vecs[i].px, vecs[i].py, got);
            chk($sformatf("vec%0d", i), {26'd0, got}, {26'd0, vecs[i].exp});
        end

        // Shadowing: mid-frame move waits for the next frame_tick
        p0_x = 10'd100; p0_y = 9'd50; p0_dir = 1'b0; p0_en = 1'b1; p1_en = 1'b0;
        tick();
        p0_x = 10'd300;
        probe(106, 50, got); chk("shadow_old_pos", {26'd0, got}, {26'd0, RED});
        probe(306, 50, got); chk("shadow_new_early", {26'd0, got}, {26'd0, SKY});
        tick();
        probe(306, 50, got); chk("shadow_new_pos", {26'd0, got}, {26'd0, RED});
        probe(106, 50, got); chk("shadow_old_gone", {26'd0, got}, {26'd0, SKY});

        // Collision: overlap sets collide, moving apart clears it a frame later
        p0_x = 10'd200; p0_y = 9'd100; p1_x = 10'd200; p1_y = 9'd100; p1_en = 1'b1;
        tick();
        probe(200, 107, got);
        tick();
        chk("collide_set", {31'd0, collide}, 32'd1);
        p1_x = 10'd400; p1_y = 9'd300;
        probe(200, 107, got);
        tick();
        chk("collide_held", {31'd0, collide}, 32'd1);
        probe(200, 107, got);
        probe(400, 307, got);
        tick();
        chk("collide_clear", {31'd0, collide}, 32'd0);

        // Randomized sprites and pixels clustered around them
        for (int it = 0; it < 24; it++) begin
            p0_x = 10'($urandom_range(0, 639)); p0_y = 9'($urandom_range(0, 479));
            p0_dir = 1'($urandom); p0_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) begin
                p1_x = 10'(int'(p0_x) + int'($urandom_range(0, 12)));
                p1_y = 9'(int'(p0_y) + int'($urandom_range(0, 12)));
            end else begin
                p1_x = 10'($urandom_range(0, 639)); p1_y = 9'($urandom_range(0, 479));
            end
            p1_dir = 1'($urandom); p1_en = ($urandom_range(0, 7) != 0);
            tick();
            if (it == 12) do_reset(3);
            for (int k = 0; k < 150; k++) begin
                int px, py;
                px = int'(p0_x) + int'($urandom_range(0, 30)) - 4;
                py = int'(p0_y) + int'($urandom_range(0, 30)) - 4;
                if (px < 0) px = 0;
                if (px > 639) px = 639;
                if (py < 0) py = 0;
                if (py > 479) py = 479;
                drive(px, py, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 99) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
